// File: rtl/out_display_pkg.sv
// Shared types and constants for the out_display 7-segment driver.
package out_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_t;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  function automatic logic [11:0] dd_adjust(input logic [11:0] bcd);
    logic [11:0] r;
    r = bcd;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5)
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/out_display_if.sv
// Port-byte input and segment/busy outputs of the display driver.
interface out_display_if;
  logic [7:0] DataIn;
  logic       busy;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;

  modport master (
    output DataIn,
    input  busy, HEX0, HEX1, HEX2, HEX3
  );

  modport slave (
    input  DataIn,
    output busy, HEX0, HEX1, HEX2, HEX3
  );
endinterface

// File: rtl/out_display_seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_decoder (
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'b1111111;
    case (i_bcd)
      4'd0: o_seg = 7'b1000000;
      4'd1: o_seg = 7'b1111001;
      4'd2: o_seg = 7'b0100100;
      4'd3: o_seg = 7'b0110000;
      4'd4: o_seg = 7'b0011001;
      4'd5: o_seg = 7'b0010010;
      4'd6: o_seg = 7'b0000010;
      4'd7: o_seg = 7'b1111000;
      4'd8: o_seg = 7'b0000000;
      4'd9: o_seg = 7'b0010000;
      default: o_seg = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/out_display.sv
// Port byte to four 7-segment displays via one-bit-per-clock double dabble.
// OUT_DISPLAY_SIGNED_EN: treat the byte as two's complement with sign on HEX3.
module out_display
  import out_display_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  out_display_if.slave bus
);

  state_t           r_state;
  logic [7:0]       r_shadow;
  logic [7:0]       r_bin;
  logic [11:0]      r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;
  logic             r_busy;
  logic [6:0]       r_hex0, r_hex1, r_hex2, r_hex3;

  logic [11:0]      w_adj;
  logic [7:0]       w_mag;
  logic             w_neg;
  logic [6:0]       w_seg0, w_seg1, w_seg2;

`ifdef OUT_DISPLAY_SIGNED_EN
  assign w_neg = bus.DataIn[7];
  assign w_mag = w_neg ? (~bus.DataIn + 8'd1) : bus.DataIn;
`else
  assign w_neg = 1'b0;
  assign w_mag = bus.DataIn;
`endif

  assign w_adj = dd_adjust(r_bcd);

  seg7_decoder u_dec0 (.i_bcd(r_bcd[3:0]),  .o_seg(w_seg0));
  seg7_decoder u_dec1 (.i_bcd(r_bcd[7:4]),  .o_seg(w_seg1));
  seg7_decoder u_dec2 (.i_bcd(r_bcd[11:8]), .o_seg(w_seg2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_hex0   <= 7'b1000000;
      r_hex1   <= SEG_BLANK;
      r_hex2   <= SEG_BLANK;
      r_hex3   <= SEG_BLANK;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.DataIn != r_shadow) begin
            r_shadow <= bus.DataIn;
            r_bin    <= w_mag;
            r_neg    <= w_neg;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          {r_bcd, r_bin} <= 20'({w_adj, r_bin} << 1);
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST)
            r_state <= UPDATE;
        end
        UPDATE: begin
          r_hex0 <= w_seg0;
          // Tens only blank when hundreds are blank too (e.g. 105 keeps its 0)
          r_hex1 <= (r_bcd[11:4] == 8'd0) ? SEG_BLANK : w_seg1;
          r_hex2 <= (r_bcd[11:8] == 4'd0) ? SEG_BLANK : w_seg2;
          r_hex3 <= r_neg ? SEG_MINUS : SEG_BLANK;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.HEX0 = r_hex0;
  assign bus.HEX1 = r_hex1;
  assign bus.HEX2 = r_hex2;
  assign bus.HEX3 = r_hex3;

endmodule

// File: tb/tb_out_display.sv
// Directed self-checking bench for out_display (unsigned or signed build).
module tb_out_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SM = 7'b0111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchecks = 0;
  int   nerr = 0;

  out_display_if bus ();

  out_display dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_hex(input string tag, input logic [6:0] e3,
                           input logic [6:0] e2, input logic [6:0] e1,
                           input logic [6:0] e0);
    check({tag, " HEX3"}, 32'(bus.HEX3), 32'(e3));
    check({tag, " HEX2"}, 32'(bus.HEX2), 32'(e2));
    check({tag, " HEX1"}, 32'(bus.HEX1), 32'(e1));
    check({tag, " HEX0"}, 32'(bus.HEX0), 32'(e0));
  endtask

  // From a negedge in IDLE: edge 0 then count busy cycles (bounded).
  task automatic measure(input string tag);
    int n;
    n = 0;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else break;
    end
    check({tag, " busy cycles"}, 32'(n), 32'd9);
  endtask

  task automatic conv(input logic [7:0] v, input string tag,
                      input logic [6:0] e3, input logic [6:0] e2,
                      input logic [6:0] e1, input logic [6:0] e0);
    bus.DataIn = v;
    measure(tag);
    check_hex(tag, e3, e2, e1, e0);
  endtask

  initial begin
    int n;
    bus.DataIn = 8'd0;
    repeat (3) @(negedge clk);
    check_hex("reset", SB, SB, SB, S0);
    check("reset busy", 32'(bus.busy), 32'd0);

    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle busy", 32'(bus.busy), 32'd0);
    check_hex("idle", SB, SB, SB, S0);

`ifdef OUT_DISPLAY_SIGNED_EN
    conv(8'd255, "d255", SM, SB, SB, S1);
`else
    conv(8'd255, "d255", SB, S2, S5, S5);
`endif
    conv(8'd7, "d7", SB, SB, SB, S7);
    conv(8'd105, "d105", SB, S1, S0, S5);

    // Change mid-conversion: 12 then 99
    bus.DataIn = 8'd12;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("mid busy", 32'(bus.busy), 32'd1);
    check("mid hold HEX0", 32'(bus.HEX0), 32'(S5));
    check("mid hold HEX2", 32'(bus.HEX2), 32'(S1));
    bus.DataIn = 8'd99;
    n = 3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else break;
    end
    check("d12 busy cycles", 32'(n), 32'd9);
    check_hex("d12", SB, SB, S1, S2);
    measure("d99");
    check_hex("d99", SB, SB, S9, S9);

`ifdef OUT_DISPLAY_SIGNED_EN
    conv(8'hFF, "hFF", SM, SB, SB, S1);
    conv(8'h80, "h80", SM, S1, S2, S8);
`else
    conv(8'hFF, "hFF", SB, S2, S5, S5);
    conv(8'h80, "h80", SB, S1, S2, S8);
`endif

    // Async reset during SHIFT of 200
    bus.DataIn = 8'd200;
    @(posedge clk);
    repeat (4) @(negedge clk);
    check("pre-rst busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(bus.busy), 32'd0);
    check_hex("async rst", SB, SB, SB, S0);
    @(negedge clk);
    check_hex("rst held", SB, SB, SB, S0);
    rst_n = 1'b1;
    measure("d200");
`ifdef OUT_DISPLAY_SIGNED_EN
    check_hex("d200", SM, SB, S5, S6);
`else
    check_hex("d200", SB, S2, S0, S0);
`endif

    repeat (3) @(negedge clk);
    check("final idle busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
